clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000000: clk cycles per tick_1hz period.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive equal samples required to accept a button level.
REQ-003 Parameter SET_TIMEOUT, default 30: tick_1hz periods without a button press before a set mode exits automatically.
REQ-004 Parameter REPEAT_CYCLES, default 12500000: auto-repeat interval; used only when AUTO_REPEAT_EN is defined.
REQ-005 clk  in  1  single clock; all state is updated on the positive edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
REQ-008 btn_inc  in  1  raw increment button, active-high, asynchronous to clk.
REQ-009 tick_1hz  out  1  one-cycle pulse once per CLK_DIV cycles; drives the seconds counter.
REQ-010 hold  out  3  counter control code: 000 run, 001 freeze/resync, 010 minute-increment pulse, 100 hour-increment pulse.
REQ-011 sel  out  2  field being edited: 00 none, 01 hour, 10 minute.
REQ-012 blink  out  1  display blank strobe for the selected field.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 and wraps; tick_1hz is high for exactly the cycle in which count==CLK_DIV-1, in every state.
REQ-014 Each button passes through a 2-FF synchronizer, then a debouncer whose stable level changes only after DEBOUNCE_CYCLES consecutive samples differ from it.
REQ-015 A press event is a one-cycle pulse on a 0->1 transition of the stable level; a release produces no event.
REQ-016 FSM states RUN, SET_HOUR, SET_MIN; a mode press moves RUN->SET_HOUR->SET_MIN->RUN.
REQ-017 RUN: hold=000, sel=00, blink=0; inc presses are ignored.
REQ-018 SET_HOUR: sel=01, hold=001; an inc press drives hold=100 for exactly one cycle, then hold returns to 001.
REQ-019 SET_MIN: sel=10, hold=001; an inc press drives hold=010 for exactly one cycle, then hold returns to 001.
REQ-020 All outputs are registered; hold/sel reflect a state change or press event on the clock edge after the event pulse (1-cycle latency).
REQ-021 When mode and inc press events occur in the same cycle, mode wins and the inc event is discarded.
REQ-022 blink is set to 1 on entry to a set state and toggles on each tick_1hz while in a set state.
REQ-023 A timeout counter clears on entry to a set state and on every press event, increments on each tick_1hz, and forces the FSM to RUN when it reaches SET_TIMEOUT.
REQ-024 When a timeout and a press event coincide, the press event is taken and the timeout counter clears.
REQ-025 The timeout counter saturates and never wraps; in RUN it is held at 0.

Reset
REQ-026 While rst=1: state=RUN, tick_1hz=0, hold=000, sel=00, blink=0, and all prescaler, debounce and timeout counters and stable levels are 0.
REQ-027 Asserting rst mid-edit (including during a hold=100/010 pulse) returns the block to RUN immediately, with no further increment pulse.
REQ-028 A button held through reset release yields exactly one press event, after DEBOUNCE_CYCLES cycles.

Configuration
REQ-029 With AUTO_REPEAT_EN defined, when the inc stable level stays high in a set state, a further increment pulse is issued every REPEAT_CYCLES cycles after the initial press, and each repeat clears the timeout counter.
REQ-030 With AUTO_REPEAT_EN undefined, there is exactly one increment pulse per press, REPEAT_CYCLES is unused, and no repeat counter is instantiated.

Verification (CLK_DIV=10, DEBOUNCE_CYCLES=4, SET_TIMEOUT=3, REPEAT_CYCLES=8)
REQ-031 Release rst and run 40 cycles -> tick_1hz pulses on cycles 10, 20, 30 and 40 only; hold=000 throughout.
REQ-032 Apply a 3-cycle glitch on btn_mode -> no state change; hold a 6-cycle press -> SET_HOUR, sel=01, hold=001, blink=1.
REQ-033 In SET_HOUR, one inc press -> hold=100 for one cycle; second mode press -> SET_MIN; inc press -> hold=010 for one cycle.
REQ-034 Mode and inc press events in the same cycle while in SET_MIN -> state RUN, hold=000, no 010 pulse.
REQ-035 Enter SET_HOUR and leave buttons idle -> blink toggles on each tick; state returns to RUN on the 3rd tick.
REQ-036 With AUTO_REPEAT_EN defined, hold inc for 30 cycles in SET_MIN -> initial 010 pulse followed by repeats 8 cycles apart; without the macro -> a single pulse.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Clock time-set controller: 1 Hz prescaler, button conditioning and the RUN/SET_HOUR/SET_MIN FSM.
// Define AUTO_REPEAT_EN to auto-repeat increment pulses while inc is held in a set state.
module clock_set_ctrl #(
    parameter int unsigned CLK_DIV         = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SET_TIMEOUT     = 30,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       tick_1hz,
    output logic [2:0] hold,
    output logic [1:0] sel,
    output logic       blink
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TO_W  = $clog2(SET_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt_c;
    logic [1:0]       raw_c;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [1:0]       press_c;
    logic [DEB_W-1:0] deb_cnt [2];
    logic             mode_press_c;
    logic             inc_press_c;
    logic             rpt_c;
    logic             inc_evt_c;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout_c;
    logic [2:0]       hold_nxt;
    logic [1:0]       sel_nxt;
    logic             blink_nxt;

    // Free-running prescaler; tick is registered so it lines up with the terminal count.
    assign div_nxt_c = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            tick_1hz <= 1'b0;
        end else begin
            div_cnt  <= div_nxt_c;
            tick_1hz <= (div_nxt_c == DIV_W'(CLK_DIV - 1));
        end
    end

    // Bit 0 is mode, bit 1 is inc: two-stage synchronizer then level debouncer.
    assign raw_c = {btn_inc, btn_mode};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a     <= '0;
            sync_b     <= '0;
            stable     <= '0;
            stable_d   <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_a   <= raw_c;
            sync_b   <= sync_a;
            stable_d <= stable;
            for (int b = 0; b < 2; b++) begin
                if (sync_b[b] == stable[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[b]  <= sync_b[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
                end
            end
        end
    end

    assign press_c      = stable & ~stable_d;
    assign mode_press_c = press_c[0];
    assign inc_press_c  = press_c[1];

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RPT_W-1:0] rpt_cnt;

    // Repeat fires every REPEAT_CYCLES cycles counted from the initial press.
    assign rpt_c = (state != RUN) && stable[1] && !inc_press_c && !mode_press_c &&
                   (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if ((state == RUN) || !stable[1] || inc_press_c || mode_press_c || rpt_c) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign rpt_c = 1'b0;
`endif

    assign inc_evt_c = inc_press_c | rpt_c;
    assign timeout_c = tick_1hz && (to_cnt >= TO_W'(SET_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode press has priority; any press event in a set state overrides the timeout.
    always_comb begin
        state_nxt = state;
        if (mode_press_c) begin
            case (state)
                RUN:      state_nxt = SET_HOUR;
                SET_HOUR: state_nxt = SET_MIN;
                default:  state_nxt = RUN;
            endcase
        end else if ((state != RUN) && !inc_evt_c && timeout_c) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        hold_nxt  = 3'b000;
        sel_nxt   = 2'b00;
        blink_nxt = 1'b0;
        if (state_nxt != RUN) begin
            sel_nxt  = 2'(state_nxt);
            hold_nxt = 3'b001;
            if ((state_nxt == state) && inc_evt_c) begin
                hold_nxt = (state == SET_HOUR) ? 3'b100 : 3'b010;
            end
            if (state_nxt != state) begin
                blink_nxt = 1'b1;
            end else if (tick_1hz) begin
                blink_nxt = ~blink;
            end else begin
                blink_nxt = blink;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold  <= 3'b000;
            sel   <= 2'b00;
            blink <= 1'b0;
        end else begin
            hold  <= hold_nxt;
            sel   <= sel_nxt;
            blink <= blink_nxt;
        end
    end

    // Idle timer: held at zero in RUN, restarted by entries and press events, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state_nxt == RUN) || (state_nxt != state) || mode_press_c || inc_evt_c) begin
            to_cnt <= '0;
        end else if (tick_1hz && (to_cnt != TO_W'(SET_TIMEOUT))) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small parameters (CLK_DIV=10, DEBOUNCE_CYCLES=4, SET_TIMEOUT=3, REPEAT_CYCLES=8).
module tb_clock_set_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic       tick_1hz;
    logic [2:0] hold;
    logic [1:0] sel;
    logic       blink;

    int checks = 0;
    int errors = 0;

    clock_set_ctrl #(
        .CLK_DIV         (10),
        .DEBOUNCE_CYCLES (4),
        .SET_TIMEOUT     (3),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .tick_1hz (tick_1hz),
        .hold     (hold),
        .sel      (sel),
        .blink    (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       i;
        int         len;
        logic [1:0] sel;
        logic [2:0] hold;
        int         n100;
        int         n010;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Buttons rise at the current negedge, stay high for len edges, window lasts total edges.
    task automatic drive(input logic m, input logic i, input int len, input int total,
                         output int n100, output int n010, output int first010, output int last010);
        n100 = 0; n010 = 0; first010 = 0; last010 = 0;
        btn_mode = m;
        btn_inc  = i;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (hold == 3'b100) n100++;
            if (hold == 3'b010) begin
                n010++;
                if (first010 == 0) first010 = k;
                last010 = k;
            end
            if (k == len) begin
                btn_mode = 1'b0;
                btn_inc  = 1'b0;
            end
        end
    endtask

    initial begin
        int n100, n010, f010, l010, bad, got, nt;
        logic prev;

        //            m     i     len  sel    hold    n100 n010
        vecs[0] = '{1'b0, 1'b1, 6, 2'b00, 3'b000, 0, 0};  // inc ignored in RUN
        vecs[1] = '{1'b1, 1'b0, 3, 2'b00, 3'b000, 0, 0};  // mode glitch rejected
        vecs[2] = '{1'b1, 1'b0, 6, 2'b01, 3'b001, 0, 0};  // enter SET_HOUR
        vecs[3] = '{1'b0, 1'b1, 6, 2'b01, 3'b001, 1, 0};  // hour increment
        vecs[4] = '{1'b1, 1'b0, 6, 2'b10, 3'b001, 0, 0};  // enter SET_MIN
        vecs[5] = '{1'b0, 1'b1, 6, 2'b10, 3'b001, 0, 1};  // minute increment
        vecs[6] = '{1'b1, 1'b1, 6, 2'b00, 3'b000, 0, 0};  // mode wins over inc

        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tick", int'(tick_1hz), 0);
        check("reset_hold", int'(hold), 0);
        check("reset_sel", int'(sel), 0);
        check("reset_blink", int'(blink), 0);

        rst = 1'b0;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("tick_cycle%0d", k), int'(tick_1hz), (k % 10 == 9) ? 1 : 0);
            if (hold != 3'b000) bad++;
        end
        check("run_hold_nonzero", bad, 0);

        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].m, vecs[v].i, vecs[v].len, 12, n100, n010, f010, l010);
            check($sformatf("vec%0d_sel", v), int'(sel), int'(vecs[v].sel));
            check($sformatf("vec%0d_hold", v), int'(hold), int'(vecs[v].hold));
            check($sformatf("vec%0d_n100", v), n100, vecs[v].n100);
            check($sformatf("vec%0d_n010", v), n010, vecs[v].n010);
        end

        // Idle timeout from SET_HOUR with blink toggling on each tick.
        btn_mode = 1'b1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) btn_mode = 1'b0;
            if (sel == 2'b01) begin
                got = k;
                break;
            end
        end
        btn_mode = 1'b0;
        check("to_entry_cycle", got, 7);
        check("to_entry_blink", int'(blink), 1);
        check("to_entry_hold", int'(hold), 1);
        prev = tick_1hz;
        nt = 0;
        for (int k = 0; k < 60 && nt < 3; k++) begin
            @(negedge clk);
            if (prev) begin
                nt++;
                if (nt == 1) begin
                    check("to_tick1_sel", int'(sel), 1);
                    check("to_tick1_blink", int'(blink), 0);
                end else if (nt == 2) begin
                    check("to_tick2_sel", int'(sel), 1);
                    check("to_tick2_blink", int'(blink), 1);
                end else begin
                    check("to_tick3_sel", int'(sel), 0);
                    check("to_tick3_blink", int'(blink), 0);
                    check("to_tick3_hold", int'(hold), 0);
                end
            end
            prev = tick_1hz;
        end
        check("to_ticks_seen", nt, 3);

        // Held inc in SET_MIN: one pulse, or repeats 8 cycles apart with auto-repeat.
        drive(1'b1, 1'b0, 6, 12, n100, n010, f010, l010);
        drive(1'b1, 1'b0, 6, 12, n100, n010, f010, l010);
        check("rpt_sel_min", int'(sel), 2);
        drive(1'b0, 1'b1, 30, 40, n100, n010, f010, l010);
        check("rpt_first", f010, 7);
`ifdef AUTO_REPEAT_EN
        check("rpt_count", n010, 4);
        check("rpt_last", l010, 31);
`else
        check("rpt_count", n010, 1);
        check("rpt_last", l010, 7);
`endif

        // Reset asserted during an hour-increment pulse.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 6, 12, n100, n010, f010, l010);
        check("mid_sel_hour", int'(sel), 1);
        btn_inc = 1'b1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) btn_inc = 1'b0;
            if (hold == 3'b100) begin
                got = k;
                break;
            end
        end
        btn_inc = 1'b0;
        check("mid_pulse_cycle", got, 7);
        rst = 1'b1;
        #1;
        check("mid_rst_hold", int'(hold), 0);
        check("mid_rst_sel", int'(sel), 0);
        check("mid_rst_blink", int'(blink), 0);
        check("mid_rst_tick", int'(tick_1hz), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hold != 3'b000 || sel != 2'b00) bad++;
        end
        check("mid_post_activity", bad, 0);

        // Mode button held through reset release gives exactly one press.
        rst = 1'b1;
        btn_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel == 2'b01 && got == 0) got = k;
            if (sel == 2'b10) bad++;
        end
        btn_mode = 1'b0;
        check("held_press_cycle", got, 7);
        check("held_final_sel", int'(sel), 1);
        check("held_extra_press", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
